lane_sel_scan: RTL and testbench
================================

Name: lane_sel_scan

Overview:
Parametrised, registered lane selector that extracts one WIDTH-bit lane from a packed LANES*WIDTH bus. It is the successor to the team's combinational 9x8-bit byte selector and feeds the multiplexed display and debug readout path. Over the older selector it adds:
- a valid/ready output handshake;
- an auto-scan mode that walks all lanes in turn;
- out-of-range detection;
- configurable lane-0 zeroing.

Parameters:
LANES, 9, number of packed lanes on data_in (2..16)
WIDTH, 8, bits per lane (1..32)
SEL_W, 4, width of sel and lane_out; must satisfy 2**SEL_W >= LANES
ZERO_LANE0, 1, 1 = lane 0 always reads as all-zero; 0 = lane 0 is data_in[WIDTH-1:0]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  LANES*WIDTH  packed lanes; lane k = data_in[k*WIDTH +: WIDTH]
sel  input  SEL_W  lane index used in direct mode
mode  input  1  0 = direct (sel), 1 = scan (internal counter)
in_valid  input  1  request to capture a beat
in_ready  output  1  block can accept this cycle
out_valid  output  1  data_out/lane_out/sel_err hold a valid beat
out_ready  input  1  consumer accepts the current beat
data_out  output  WIDTH  selected lane value
lane_out  output  SEL_W  lane index the beat was taken from
sel_err  output  1  beat came from an out-of-range index

Behaviour:
Clock and reset:
- One clock domain: clk.
- rst_n is asynchronous, active-low.
- While rst_n is low: out_valid=0, data_out=0, lane_out=0, sel_err=0, scan counter=0, mode_q=0.
- Reset asserted mid-transfer drops the held beat immediately; no partial beat survives.

Handshake:
- in_ready = !out_valid | out_ready (combinational).
- accept = in_valid & in_ready.

Output register (two states, EMPTY and FULL, where out_valid = FULL):
- EMPTY --accept--> FULL.
- FULL & out_ready & !accept --> EMPTY.
- FULL & out_ready & accept --> FULL, loaded with the new beat (back-to-back, no bubble).
- FULL & !out_ready --> FULL; data_out, lane_out and sel_err are held bit-stable and in_ready=0.
- Latency: a beat accepted in cycle N is visible in cycle N+1.
- Sustained throughput: one beat per cycle.

Lane index idx:
- mode=0: idx = sel.
- mode=1: idx = scan counter.
- Sampled only in the accept cycle.

Captured data:
- idx >= LANES: data_out=0, sel_err=1, lane_out=idx.
- idx == 0 and ZERO_LANE0=1: data_out=0, sel_err=0.
- Otherwise: data_out = lane idx, sel_err=0.
- data_in is sampled only in the accept cycle. Later changes to data_in do not affect a held beat.

Scan counter (SEL_W bits, range 0..LANES-1):
- Increments by 1 on each accept while mode=1.
- Wraps from LANES-1 to 0.
- Holds when there is no accept, including during a stall.
- Never produces an out-of-range index, so scan mode never raises sel_err.

Mode changes:
- mode_q is a registered copy of mode.
- A rising edge (mode=1, mode_q=0) forces the counter to 0 in that cycle, so the first scan beat is lane 0.
- If an accept coincides with that edge, the beat uses lane 0 and the counter becomes 1.
- A falling edge leaves the counter unchanged. Direct mode ignores the counter.
- mode changes while FULL and stalled do not alter the held beat.

Test Plan:
- Reset checks: assert rst_n=0 mid-stream -> out_valid, data_out, lane_out and sel_err all go 0 immediately; in_ready=1 after release.
- Direct select: data_in=72'h99_88_77_66_55_44_33_22_11, mode=0, sel=3, in_valid=1, out_ready=1 -> next cycle out_valid=1, data_out=8'h44, lane_out=3, sel_err=0.
- Lane 0 and out-of-range:
  - sel=0 -> data_out=8'h00.
  - sel=9 and sel=15 -> data_out=8'h00, sel_err=1, lane_out=9 and 15.
  - Rerun with ZERO_LANE0=0, sel=0 -> 8'h11.
- Stall: beat sel=5 held with out_ready=0 for 4 cycles while sel and data_in change -> data_out stays 8'h66, in_ready=0. Release -> next beat is accepted the same cycle (no bubble).
- Scan wrap: mode 0->1, in_valid=1, out_ready=1 for 11 cycles -> lane_out sequence 0,1,…,8,0,1; data_out sequence 00,22,33,…,99,00,22; sel_err never set.
- Scan stall and re-entry:
  - Toggle out_ready 1/0 every cycle in scan -> each lane appears exactly once per wrap, none skipped or repeated.
  - Return to mode=0, then back to 1 -> scan restarts at lane 0.

Source files
------------

// File: rtl/lane_sel_scan.sv
// rtl/lane_sel_scan.sv - registered lane selector with valid/ready output and auto-scan
module lane_sel_scan #(
    parameter int LANES      = 9,
    parameter int WIDTH      = 8,
    parameter int SEL_W      = 4,
    parameter bit ZERO_LANE0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic [SEL_W-1:0]       lane_out,
    output logic                   sel_err
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_cnt;
    logic             r_mode_q;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_lane;
    logic             r_err;

    logic             w_accept;
    logic             w_rise;
    logic [SEL_W-1:0] w_idx;
    logic             w_oob;
    logic [WIDTH-1:0] w_lane_val;
    logic [WIDTH-1:0] w_data;

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign data_out  = r_data;
    assign lane_out  = r_lane;
    assign sel_err   = r_err;

    // A scan entry uses lane 0 in the same cycle, before the counter is cleared.
    assign w_rise = mode && !r_mode_q;
    assign w_idx  = mode ? (w_rise ? '0 : r_cnt) : sel;
    assign w_oob  = (w_idx > LAST);

    always_comb begin
        w_lane_val = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_lane_val = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_data = w_lane_val;
        if (w_oob || (ZERO_LANE0 && (w_idx == '0))) begin
            w_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_cnt    <= '0;
            r_mode_q <= 1'b0;
            r_data   <= '0;
            r_lane   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_mode_q <= mode;

            if (w_rise) begin
                r_cnt <= w_accept ? SEL_W'(1) : '0;
            end else if (w_accept && mode) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + SEL_W'(1);
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_FULL;
                        r_data  <= w_data;
                        r_lane  <= w_idx;
                        r_err   <= w_oob;
                    end
                end
                S_FULL: begin
                    if (w_accept) begin
                        r_data <= w_data;
                        r_lane <= w_idx;
                        r_err  <= w_oob;
                    end else if (out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_sel_scan.sv
// tb/tb_lane_sel_scan.sv - scoreboard bench for lane_sel_scan
module tb_lane_sel_scan;

    localparam logic [71:0] PATTERN = 72'h99_88_77_66_55_44_33_22_11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] data_in = PATTERN;
    logic [3:0]  sel = '0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, sel_err;
    logic [7:0]  data_out;
    logic [3:0]  lane_out;
    logic        nz_in_ready, nz_out_valid, nz_sel_err;
    logic [7:0]  nz_data_out;
    logic [3:0]  nz_lane_out;

    int checks = 0;
    int errors = 0;

    logic [12:0] sb_q[$];

    logic       m_full = 1'b0;
    logic [3:0] m_cnt = '0;
    logic       m_mode_q = 1'b0;

    always #5 clk = ~clk;

    lane_sel_scan #(.LANES(9), .WIDTH(8), .SEL_W(4), .ZERO_LANE0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .lane_out(lane_out),
        .sel_err(sel_err)
    );

    lane_sel_scan #(.LANES(9), .WIDTH(8), .SEL_W(4), .ZERO_LANE0(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(nz_in_ready), .out_valid(nz_out_valid),
        .out_ready(out_ready), .data_out(nz_data_out), .lane_out(nz_lane_out),
        .sel_err(nz_sel_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern lane k holds (k+1)*8'h11; lane 0 reads zero and indices >= 9 are errors.
    function automatic logic [12:0] expect_beat(input logic [3:0] idx);
        logic [7:0] d;
        logic       e;
        e = (idx >= 4'd9);
        d = (e || idx == 4'd0) ? 8'h00 : 8'(({4'd0, idx} + 8'd1) * 8'h11);
        return {d, idx, e};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {19'd0, data_out, lane_out, sel_err}, 32'hFFFF_FFFF);
            end else begin
                chk("beat", {19'd0, data_out, lane_out, sel_err}, {19'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic cycle(input logic v, input logic m, input logic [3:0] s, input logic ordy);
        logic       acc;
        logic       rise;
        logic [3:0] idx;
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_full || ordy});
        acc  = v && (!m_full || ordy);
        rise = m && !m_mode_q;
        idx  = m ? (rise ? 4'd0 : m_cnt) : s;
        if (acc) sb_q.push_back(expect_beat(idx));
        if (rise) m_cnt = acc ? 4'd1 : 4'd0;
        else if (acc && m) m_cnt = (m_cnt == 4'd8) ? 4'd0 : m_cnt + 4'd1;
        m_mode_q = m;
        if (acc) m_full = 1'b1;
        else if (ordy) m_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cycle(1'b1, 1'b0, 4'd3, 1'b1);
        chk("direct_sel3_data", {24'd0, data_out}, 32'h44);
        cycle(1'b1, 1'b0, 4'd0, 1'b1);
        chk("nz_lane0", {24'd0, nz_data_out}, 32'h11);
        cycle(1'b1, 1'b0, 4'd9, 1'b1);
        chk("oob9_err", {31'd0, sel_err}, 32'd1);
        cycle(1'b1, 1'b0, 4'd15, 1'b1);
        chk("oob15_lane", {28'd0, lane_out}, 32'd15);

        cycle(1'b1, 1'b0, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            data_in = {$urandom, $urandom, $urandom};
            cycle(1'b1, 1'b0, 4'(i + 7), 1'b0);
            chk("stall_hold_data", {24'd0, data_out}, 32'h66);
            chk("stall_hold_lane", {28'd0, lane_out}, 32'd5);
        end
        data_in = PATTERN;
        cycle(1'b1, 1'b0, 4'd2, 1'b1);
        chk("release_no_bubble", {24'd0, data_out}, 32'h33);
        cycle(1'b0, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 4'd0, 1'b1);
        chk("scan_wrap_lane", {28'd0, lane_out}, 32'd1);
        cycle(1'b0, 1'b1, 4'd0, 1'b1);

        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 4'd0, 1'(i % 2 == 0));
        cycle(1'b0, 1'b1, 4'd0, 1'b1);

        cycle(1'b1, 1'b0, 4'd6, 1'b1);
        cycle(1'b1, 1'b0, 4'd4, 1'b1);
        cycle(1'b1, 1'b1, 4'd0, 1'b1);
        chk("scan_reentry_lane0", {28'd0, lane_out}, 32'd0);
        cycle(1'b1, 1'b1, 4'd0, 1'b1);
        cycle(1'b1, 1'b1, 4'd0, 1'b0);

        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, data_out}, 32'd0);
        chk("midrst_lane", {28'd0, lane_out}, 32'd0);
        chk("midrst_err", {31'd0, sel_err}, 32'd0);
        sb_q.delete();
        m_full = 1'b0;
        m_cnt = '0;
        m_mode_q = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        cycle(1'b1, 1'b1, 4'd0, 1'b1);
        chk("post_rst_scan_lane0", {28'd0, lane_out}, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 4'd0, 1'b1);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
